// File: rtl/hawk_axi_rr_arbiter.sv
// hawk_axi_rr_arbiter
// N-master to 1-slave AXI4 arbiter. The write path (AW/W/B) and the read
// path (AR/R) each run a small FSM that arbitrates independently. Each path
// chooses a master either round-robin or by a software-forced static
// select, and it holds the grant for one complete transaction. The write
// path also flags W bursts whose beat count does not match AWLEN.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   static_en_i, static_sel_i  static select mode and the master it selects
//   s_aw_* / s_w_* / s_b_*     per-master write channels (B payload broadcast)
//   s_ar_* / s_r_*             per-master read channels (R payload broadcast)
//   m_aw_* ... m_r_*           single downstream port, same payload packing
//   wr_busy_o, rd_busy_o       path currently holds a grant
//   wr_grant_o, rd_grant_o     current or most recent grant index
//   wr_len_err_o               one-cycle pulse on a W burst length mismatch
module hawk_axi_rr_arbiter #(
  parameter int NUM_MSTR = 2,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 4,
  parameter int USER_W   = 1,
  parameter int STRB_W   = DATA_W / 8,
  parameter int SEL_W    = $clog2(NUM_MSTR),
  parameter int AX_W     = ADDR_W + ID_W + USER_W + 29,
  parameter int W_W      = DATA_W + STRB_W + USER_W,
  parameter int R_W      = DATA_W + 2 + ID_W + USER_W,
  parameter int B_W      = 2 + ID_W + USER_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     static_en_i,
  input  logic [SEL_W-1:0]         static_sel_i,
  input  logic [NUM_MSTR-1:0]      s_aw_valid_i,
  output logic [NUM_MSTR-1:0]      s_aw_ready_o,
  input  logic [NUM_MSTR*AX_W-1:0] s_aw_pld_i,
  input  logic [NUM_MSTR-1:0]      s_w_valid_i,
  input  logic [NUM_MSTR-1:0]      s_w_last_i,
  output logic [NUM_MSTR-1:0]      s_w_ready_o,
  input  logic [NUM_MSTR*W_W-1:0]  s_w_pld_i,
  output logic [NUM_MSTR-1:0]      s_b_valid_o,
  input  logic [NUM_MSTR-1:0]      s_b_ready_i,
  output logic [B_W-1:0]           s_b_pld_o,
  input  logic [NUM_MSTR-1:0]      s_ar_valid_i,
  output logic [NUM_MSTR-1:0]      s_ar_ready_o,
  input  logic [NUM_MSTR*AX_W-1:0] s_ar_pld_i,
  output logic [NUM_MSTR-1:0]      s_r_valid_o,
  output logic [NUM_MSTR-1:0]      s_r_last_o,
  input  logic [NUM_MSTR-1:0]      s_r_ready_i,
  output logic [R_W-1:0]           s_r_pld_o,
  output logic                     m_aw_valid_o,
  input  logic                     m_aw_ready_i,
  output logic [AX_W-1:0]          m_aw_pld_o,
  output logic                     m_w_valid_o,
  output logic                     m_w_last_o,
  input  logic                     m_w_ready_i,
  output logic [W_W-1:0]           m_w_pld_o,
  input  logic                     m_b_valid_i,
  output logic                     m_b_ready_o,
  input  logic [B_W-1:0]           m_b_pld_i,
  output logic                     m_ar_valid_o,
  input  logic                     m_ar_ready_i,
  output logic [AX_W-1:0]          m_ar_pld_o,
  input  logic                     m_r_valid_i,
  input  logic                     m_r_last_i,
  output logic                     m_r_ready_o,
  input  logic [R_W-1:0]           m_r_pld_i,
  output logic                     wr_busy_o,
  output logic                     rd_busy_o,
  output logic [SEL_W-1:0]         wr_grant_o,
  output logic [SEL_W-1:0]         rd_grant_o,
  output logic                     wr_len_err_o
);

  // The len field sits above user, region, qos, prot, cache, lock, burst and size.
  localparam int LEN_LSB = USER_W + 21;
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_MSTR - 1);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  // Returns {found, index}. The round-robin scan runs from far to near so
  // that the nearest requester above ptr, with wrap-around, is the last one
  // assigned and therefore wins.
  function automatic logic [SEL_W:0] arb_pick(input logic [NUM_MSTR-1:0] req,
                                              input logic [SEL_W-1:0]    ptr,
                                              input logic                st_en,
                                              input logic [SEL_W-1:0]    st_sel);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    if (st_en) begin
      if (int'(st_sel) < NUM_MSTR) begin
        if (req[st_sel]) begin
          found = 1'b1;
          idx   = st_sel;
        end
      end
    end else begin
      for (int k = NUM_MSTR; k >= 1; k--) begin
        cand = SEL_W'((int'(ptr) + k) % NUM_MSTR);
        if (req[cand]) begin
          found = 1'b1;
          idx   = cand;
        end
      end
    end
    return {found, idx};
  endfunction

  // ---------------------------------------------------------------- write path
  logic [1:0]       wr_state_q, wr_state_d;
  logic [SEL_W-1:0] wr_grant_q, wr_grant_d;
  logic [SEL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       wr_len_q, wr_len_d;
  logic [7:0]       wr_beat_q, wr_beat_d;
  logic             wr_err_q, wr_err_d;
  logic [SEL_W:0]   wr_pick;

  assign wr_pick = arb_pick(s_aw_valid_i, wr_ptr_q, static_en_i, static_sel_i);

  always_comb begin
    wr_state_d = wr_state_q;
    wr_grant_d = wr_grant_q;
    wr_ptr_d   = wr_ptr_q;
    wr_len_d   = wr_len_q;
    wr_beat_d  = wr_beat_q;
    wr_err_d   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (wr_pick[SEL_W]) begin
          wr_grant_d = wr_pick[SEL_W-1:0];
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (m_aw_valid_o && m_aw_ready_i) begin
          wr_len_d   = m_aw_pld_o[LEN_LSB +: 8];
          wr_beat_d  = '0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (m_w_valid_o && m_w_ready_i) begin
          wr_beat_d = wr_beat_q + 8'd1;
          // Beats are forwarded regardless of the error; only wlast ends the burst.
          wr_err_d  = m_w_last_o ? (wr_beat_q != wr_len_q) : (wr_beat_q == wr_len_q);
          if (m_w_last_o) begin
            wr_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (m_b_valid_i && m_b_ready_o) begin
          wr_ptr_d   = wr_grant_q;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state_q <= W_IDLE;
      wr_grant_q <= '0;
      wr_ptr_q   <= PTR_RST;
      wr_len_q   <= '0;
      wr_beat_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_grant_q <= wr_grant_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_len_q   <= wr_len_d;
      wr_beat_q  <= wr_beat_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Only the grantee sees handshakes; payloads follow the grant and are
  // qualified by valid.
  always_comb begin
    s_aw_ready_o = '0;
    s_w_ready_o  = '0;
    s_b_valid_o  = '0;
    m_aw_valid_o = 1'b0;
    m_w_valid_o  = 1'b0;
    m_w_last_o   = 1'b0;
    m_b_ready_o  = 1'b0;
    m_aw_pld_o   = s_aw_pld_i[wr_grant_q*AX_W +: AX_W];
    m_w_pld_o    = s_w_pld_i[wr_grant_q*W_W +: W_W];
    case (wr_state_q)
      W_ADDR: begin
        m_aw_valid_o             = s_aw_valid_i[wr_grant_q];
        s_aw_ready_o[wr_grant_q] = m_aw_ready_i;
      end
      W_DATA: begin
        m_w_valid_o             = s_w_valid_i[wr_grant_q];
        m_w_last_o              = s_w_last_i[wr_grant_q];
        s_w_ready_o[wr_grant_q] = m_w_ready_i;
      end
      W_RESP: begin
        s_b_valid_o[wr_grant_q] = m_b_valid_i;
        m_b_ready_o             = s_b_ready_i[wr_grant_q];
      end
      default: ;
    endcase
  end

  assign s_b_pld_o    = m_b_pld_i;
  assign wr_busy_o    = (wr_state_q != W_IDLE);
  assign wr_grant_o   = wr_grant_q;
  assign wr_len_err_o = wr_err_q;

  // ----------------------------------------------------------------- read path
  logic [1:0]       rd_state_q, rd_state_d;
  logic [SEL_W-1:0] rd_grant_q, rd_grant_d;
  logic [SEL_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SEL_W:0]   rd_pick;

  assign rd_pick = arb_pick(s_ar_valid_i, rd_ptr_q, static_en_i, static_sel_i);

  always_comb begin
    rd_state_d = rd_state_q;
    rd_grant_d = rd_grant_q;
    rd_ptr_d   = rd_ptr_q;
    case (rd_state_q)
      R_IDLE: begin
        if (rd_pick[SEL_W]) begin
          rd_grant_d = rd_pick[SEL_W-1:0];
          rd_state_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (m_ar_valid_o && m_ar_ready_i) begin
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (m_r_valid_i && m_r_ready_o && m_r_last_i) begin
          rd_ptr_d   = rd_grant_q;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state_q <= R_IDLE;
      rd_grant_q <= '0;
      rd_ptr_q   <= PTR_RST;
    end else begin
      rd_state_q <= rd_state_d;
      rd_grant_q <= rd_grant_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_comb begin
    s_ar_ready_o = '0;
    s_r_valid_o  = '0;
    s_r_last_o   = '0;
    m_ar_valid_o = 1'b0;
    m_r_ready_o  = 1'b0;
    m_ar_pld_o   = s_ar_pld_i[rd_grant_q*AX_W +: AX_W];
    case (rd_state_q)
      R_ADDR: begin
        m_ar_valid_o             = s_ar_valid_i[rd_grant_q];
        s_ar_ready_o[rd_grant_q] = m_ar_ready_i;
      end
      R_DATA: begin
        s_r_valid_o[rd_grant_q] = m_r_valid_i;
        s_r_last_o[rd_grant_q]  = m_r_last_i;
        m_r_ready_o             = s_r_ready_i[rd_grant_q];
      end
      default: ;
    endcase
  end

  assign s_r_pld_o  = m_r_pld_i;
  assign rd_busy_o  = (rd_state_q != R_IDLE);
  assign rd_grant_o = rd_grant_q;

endmodule

// File: tb/tb_hawk_axi_rr_arbiter.sv
module tb_hawk_axi_rr_arbiter;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int AXW = 16 + 4 + 1 + 29;
  localparam int WPW = 32 + 4 + 1;
  localparam int BPW = 2 + 4 + 1;
  localparam int RPW = 32 + 2 + 4 + 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic static_en_i;
  logic [SW-1:0] static_sel_i;
  logic [N-1:0] s_aw_valid_i, s_aw_ready_o, s_w_valid_i, s_w_last_i, s_w_ready_o;
  logic [N-1:0] s_b_valid_o, s_b_ready_i, s_ar_valid_i, s_ar_ready_o;
  logic [N-1:0] s_r_valid_o, s_r_last_o, s_r_ready_i;
  logic [N*AXW-1:0] s_aw_pld_i, s_ar_pld_i;
  logic [N*WPW-1:0] s_w_pld_i;
  logic [BPW-1:0] s_b_pld_o, m_b_pld_i;
  logic [RPW-1:0] s_r_pld_o, m_r_pld_i;
  logic m_aw_valid_o, m_aw_ready_i, m_w_valid_o, m_w_last_o, m_w_ready_i;
  logic m_b_valid_i, m_b_ready_o, m_ar_valid_o, m_ar_ready_i;
  logic m_r_valid_i, m_r_last_i, m_r_ready_o;
  logic [AXW-1:0] m_aw_pld_o, m_ar_pld_o;
  logic [WPW-1:0] m_w_pld_o;
  logic wr_busy_o, rd_busy_o, wr_len_err_o;
  logic [SW-1:0] wr_grant_o, rd_grant_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hawk_axi_rr_arbiter #(.NUM_MSTR(N), .ADDR_W(16), .DATA_W(32), .ID_W(4), .USER_W(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .static_en_i(static_en_i), .static_sel_i(static_sel_i),
    .s_aw_valid_i(s_aw_valid_i), .s_aw_ready_o(s_aw_ready_o), .s_aw_pld_i(s_aw_pld_i),
    .s_w_valid_i(s_w_valid_i), .s_w_last_i(s_w_last_i), .s_w_ready_o(s_w_ready_o),
    .s_w_pld_i(s_w_pld_i), .s_b_valid_o(s_b_valid_o), .s_b_ready_i(s_b_ready_i),
    .s_b_pld_o(s_b_pld_o), .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o),
    .s_ar_pld_i(s_ar_pld_i), .s_r_valid_o(s_r_valid_o), .s_r_last_o(s_r_last_o),
    .s_r_ready_i(s_r_ready_i), .s_r_pld_o(s_r_pld_o),
    .m_aw_valid_o(m_aw_valid_o), .m_aw_ready_i(m_aw_ready_i), .m_aw_pld_o(m_aw_pld_o),
    .m_w_valid_o(m_w_valid_o), .m_w_last_o(m_w_last_o), .m_w_ready_i(m_w_ready_i),
    .m_w_pld_o(m_w_pld_o), .m_b_valid_i(m_b_valid_i), .m_b_ready_o(m_b_ready_o),
    .m_b_pld_i(m_b_pld_i), .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
    .m_ar_pld_o(m_ar_pld_o), .m_r_valid_i(m_r_valid_i), .m_r_last_i(m_r_last_i),
    .m_r_ready_o(m_r_ready_o), .m_r_pld_i(m_r_pld_i),
    .wr_busy_o(wr_busy_o), .rd_busy_o(rd_busy_o), .wr_grant_o(wr_grant_o),
    .rd_grant_o(rd_grant_o), .wr_len_err_o(wr_len_err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {addr, id, len, size=2, burst=INCR, lock, cache, prot, qos, region, user}
  function automatic logic [AXW-1:0] mk_ax(input logic [15:0] addr, input logic [3:0] id,
                                           input logic [7:0] len);
    return {addr, id, len, 3'd2, 2'd1, 1'b0, 4'h0, 3'h0, 4'h0, 4'h0, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    static_en_i = 1'b0; static_sel_i = '0;
    s_aw_valid_i = '0; s_aw_pld_i = '0; s_w_valid_i = '0; s_w_last_i = '0; s_w_pld_i = '0;
    s_b_ready_i = '1; s_ar_valid_i = '0; s_ar_pld_i = '0; s_r_ready_i = '1;
    m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0; m_b_valid_i = 1'b0; m_b_pld_i = '0;
    m_ar_ready_i = 1'b0; m_r_valid_i = 1'b0; m_r_last_i = 1'b0; m_r_pld_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    step();
  endtask

  // what: 0 = downstream AW valid, 1 = any upstream B valid
  task automatic wait_for(input int what, input string tag);
    int cnt = 0;
    while (!((what == 0) ? m_aw_valid_o : (s_b_valid_o != '0)) && cnt < 30) begin
      step();
      cnt++;
    end
    check({tag, "_timeout"}, 64'(cnt < 30), 64'd1);
  endtask

  // One write burst (and optionally a concurrent read burst) with a simple
  // downstream slave model; every beat's data and routing is checked.
  task automatic run_txn(input string tag, input logic [SW-1:0] wm, input int wlen,
                         input int wlast_at, input bit do_rd, input logic [SW-1:0] rm,
                         input int rlen, input bit bp);
    int wrecv = 0;
    int rrecv = 0;
    int errs = 0;
    int cyc = 0;
    bit aw_done = 0;
    bit ar_done = 0;
    bit b_done = 0;
    bit overlap = 0;
    logic [N-1:0] wm_oh = '0;
    logic [N-1:0] rm_oh = '0;
    wm_oh[wm] = 1'b1;
    rm_oh[rm] = 1'b1;
    while (!(b_done && (!do_rd || rrecv == rlen + 1)) && cyc < 100) begin
      s_aw_valid_i = '0;
      s_aw_valid_i[wm] = !aw_done;
      s_aw_pld_i[wm*AXW +: AXW] = mk_ax(16'h1000, {2'b00, wm}, wlen[7:0]);
      s_w_valid_i = '0;
      s_w_valid_i[wm] = (wrecv <= wlast_at);
      s_w_last_i = '0;
      s_w_last_i[wm] = (wrecv == wlast_at);
      s_w_pld_i[wm*WPW +: WPW] = {32'hA000_0000 + 32'(wrecv), 4'hF, 1'b0};
      m_aw_ready_i = 1'b1;
      m_w_ready_i = bp ? (cyc[0] == 1'b0) : 1'b1;
      m_b_valid_i = (wrecv == wlast_at + 1) && !b_done;
      m_b_pld_i = {2'b00, 2'b00, wm, 1'b1};
      s_b_ready_i = '1;
      s_ar_valid_i = '0;
      s_ar_valid_i[rm] = do_rd && !ar_done;
      s_ar_pld_i[rm*AXW +: AXW] = mk_ax(16'h2000, {2'b00, rm}, rlen[7:0]);
      m_ar_ready_i = 1'b1;
      m_r_valid_i = ar_done && (rrecv <= rlen);
      m_r_last_i = (rrecv == rlen);
      m_r_pld_i = {32'hB000_0000 + 32'(rrecv), 2'b00, 4'h0, 1'b0};
      s_r_ready_i = '1;
      if (bp && cyc >= 4 && cyc < 9) s_r_ready_i[rm] = 1'b0;
      #1;
      if (m_aw_valid_o && m_aw_ready_i) begin
        check({tag, "_aw_pld"}, 64'(m_aw_pld_o), 64'(mk_ax(16'h1000, {2'b00, wm}, wlen[7:0])));
        aw_done = 1;
      end
      check({tag, "_w_ready_route"}, 64'(s_w_ready_o & ~wm_oh), 64'd0);
      if (m_w_valid_o && m_w_ready_i) begin
        check({tag, "_w_data"}, 64'(m_w_pld_o[36:5]), 64'(32'hA000_0000 + 32'(wrecv)));
        check({tag, "_w_last"}, 64'(m_w_last_o), 64'(wrecv == wlast_at));
        wrecv++;
      end
      if (s_b_valid_o != '0) begin
        check({tag, "_b_route"}, 64'(s_b_valid_o), 64'(wm_oh));
        check({tag, "_b_pld"}, 64'(s_b_pld_o), 64'({2'b00, 2'b00, wm, 1'b1}));
        b_done = 1;
      end
      if (m_ar_valid_o && m_ar_ready_i) begin
        check({tag, "_ar_pld"}, 64'(m_ar_pld_o), 64'(mk_ax(16'h2000, {2'b00, rm}, rlen[7:0])));
        ar_done = 1;
      end
      if (do_rd) check({tag, "_r_valid_route"}, 64'(s_r_valid_o & ~rm_oh), 64'd0);
      if (s_r_valid_o[rm] && s_r_ready_i[rm]) begin
        check({tag, "_r_data"}, 64'(s_r_pld_o[38:7]), 64'(32'hB000_0000 + 32'(rrecv)));
        check({tag, "_r_last"}, 64'(s_r_last_o[rm]), 64'(rrecv == rlen));
        rrecv++;
      end
      if (wr_busy_o && rd_busy_o && wr_grant_o == wm && rd_grant_o == rm) overlap = 1;
      if (wr_len_err_o) errs++;
      step();
      cyc++;
    end
    clear_inputs();
    step();
    check({tag, "_timeout"}, 64'(cyc < 100), 64'd1);
    check({tag, "_w_beats"}, 64'(wrecv), 64'(wlast_at + 1));
    check({tag, "_len_err_pulses"}, 64'(errs), 64'(wlast_at != wlen));
    if (do_rd) begin
      check({tag, "_r_beats"}, 64'(rrecv), 64'(rlen + 1));
      check({tag, "_grant_overlap"}, 64'(overlap), 64'd1);
    end
    $display("txn %s: wr m%0d %0d beats, rd %0d beats, len_err pulses %0d", tag, wm, wrecv,
             rrecv, errs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    s_aw_valid_i = '1;
    s_ar_valid_i = '1;
    repeat (2) @(posedge clk);
    #2;
    // Reset state, with requests present.
    check("rst_wr_busy", 64'(wr_busy_o), 64'd0);
    check("rst_rd_busy", 64'(rd_busy_o), 64'd0);
    check("rst_wr_grant", 64'(wr_grant_o), 64'd0);
    check("rst_rd_grant", 64'(rd_grant_o), 64'd0);
    check("rst_m_aw_valid", 64'(m_aw_valid_o), 64'd0);
    check("rst_s_aw_ready", 64'(s_aw_ready_o), 64'd0);
    check("rst_len_err", 64'(wr_len_err_o), 64'd0);
    do_reset();

    // Fairness: every master requests len=0 writes continuously.
    s_aw_valid_i = '1; s_w_valid_i = '1; s_w_last_i = '1;
    for (int i = 0; i < N; i++) s_aw_pld_i[i*AXW +: AXW] = mk_ax(16'(i), 4'(i), 8'd0);
    m_aw_ready_i = 1'b1; m_w_ready_i = 1'b1; m_b_valid_i = 1'b1;
    for (int t = 0; t < 9; t++) begin
      wait_for(0, "fair_aw");
      check("fair_grant", 64'(wr_grant_o), 64'(t % N));
      check("fair_aw_ready", 64'(s_aw_ready_o), 64'(4'b0001 << (t % N)));
      check("fair_aw_pld", 64'(m_aw_pld_o), 64'(mk_ax(16'(t % N), 4'(t % N), 8'd0)));
      wait_for(1, "fair_b");
      check("fair_b_route", 64'(s_b_valid_o), 64'(4'b0001 << (t % N)));
      $display("txn fair %0d: write granted to m%0d", t, wr_grant_o);
      step();
    end

    // Reset in the middle of a W burst (master 1 granted, W stalled).
    m_w_ready_i = 1'b0;
    wait_for(0, "rstmid_aw");
    check("rstmid_grant", 64'(wr_grant_o), 64'd1);
    step();
    check("rstmid_w_valid_pre", 64'(m_w_valid_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("rstmid_busy", 64'(wr_busy_o), 64'd0);
    check("rstmid_w_valid", 64'(m_w_valid_o), 64'd0);
    check("rstmid_w_ready", 64'(s_w_ready_o), 64'd0);
    check("rstmid_aw_ready", 64'(s_aw_ready_o), 64'd0);
    check("rstmid_grant_cleared", 64'(wr_grant_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    m_w_ready_i = 1'b1;
    step();
    wait_for(0, "rstmid_regrant");
    check("rstmid_first_grant", 64'(wr_grant_o), 64'd0);
    $display("txn reset: first grant after reset m%0d", wr_grant_o);
    do_reset();

    // Static select: masters 0 and 2 request, select 2.
    static_en_i = 1'b1; static_sel_i = 2'd2;
    s_aw_valid_i = 4'b0101; s_w_valid_i = '1; s_w_last_i = '1;
    for (int i = 0; i < N; i++) s_aw_pld_i[i*AXW +: AXW] = mk_ax(16'(32'h3000 + i), 4'(i), 8'd0);
    m_aw_ready_i = 1'b1; m_w_ready_i = 1'b0; m_b_valid_i = 1'b1;
    wait_for(0, "static_aw");
    check("static_grant", 64'(wr_grant_o), 64'd2);
    check("static_aw_ready", 64'(s_aw_ready_o), 64'b0100);
    check("static_aw_pld", 64'(m_aw_pld_o), 64'(mk_ax(16'h3002, 4'd2, 8'd0)));
    step();
    static_sel_i = 2'd0;
    step();
    step();
    check("static_hold_grant", 64'(wr_grant_o), 64'd2);
    check("static_hold_wvalid", 64'(m_w_valid_o), 64'd1);
    m_w_ready_i = 1'b1;
    wait_for(1, "static_b");
    check("static_b_route", 64'(s_b_valid_o), 64'b0100);
    $display("txn static: write granted to m2");
    step();
    wait_for(0, "static_aw2");
    check("static_new_sel_grant", 64'(wr_grant_o), 64'd0);
    static_sel_i = 2'd1;
    wait_for(1, "static_b2");
    check("static_b2_route", 64'(s_b_valid_o), 64'b0001);
    $display("txn static: write granted to m0");
    step();
    repeat (6) step();
    check("static_idle_busy", 64'(wr_busy_o), 64'd0);
    check("static_grant_holds", 64'(wr_grant_o), 64'd0);
    do_reset();

    // Concurrency, backpressure, length error.
    run_txn("concurrent", 2'd1, 3, 3, 1'b1, 2'd0, 7, 1'b0);
    run_txn("backpressure", 2'd1, 3, 3, 1'b1, 2'd0, 7, 1'b1);
    run_txn("len_err", 2'd0, 3, 1, 1'b0, 2'd0, 0, 1'b0);
    run_txn("len_ok", 2'd2, 3, 3, 1'b0, 2'd0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hawk_axi_rr_arbiter.md
Name: hawk_axi_rr_arbiter

Overview:
Parametrised N-master to 1-slave AXI4 arbiter. It replaces the static 2:1 master select in front of the HACD-to-MC downsizer. Write (AW/W/B) and read (AR/R) paths arbitrate independently with round-robin fairness, or with a software-forced static select. Each grant is held for one complete transaction, and the block flags write bursts whose beat count does not match AWLEN.

Parameters:
NUM_MSTR, 2, number of upstream masters (2..8)
ADDR_W, 64, address width
DATA_W, 512, data width; STRB_W = DATA_W/8
ID_W, 4, ID width
USER_W, 1, user width
SEL_W, $clog2(NUM_MSTR), select/grant width (derived)
AX_W, ADDR_W+ID_W+USER_W+29, AW/AR payload width (derived)
Payload packing, MSB to LSB: {addr, id, len[8], size[3], burst[2], lock, cache[4], prot[3], qos[4], region[4], user}
W payload: {data, strb, user}; R payload: {data, resp[2], id, user}; B payload: {resp[2], id, user}

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
static_en_i  in  1  1 = static select mode
static_sel_i  in  SEL_W  master index used in static mode
s_aw_valid_i/s_aw_ready_o  in/out  NUM_MSTR  per-master AW handshake
s_aw_pld_i  in  NUM_MSTR*AX_W  per-master AW payload
s_w_valid_i/s_w_last_i/s_w_ready_o  in/in/out  NUM_MSTR  per-master W handshake
s_w_pld_i  in  NUM_MSTR*(DATA_W+STRB_W+USER_W)  W payload
s_b_valid_o/s_b_ready_i  out/in  NUM_MSTR  B handshake
s_b_pld_o  out  2+ID_W+USER_W  B payload, broadcast to all masters
s_ar_valid_i/s_ar_ready_o  in/out  NUM_MSTR  AR handshake
s_ar_pld_i  in  NUM_MSTR*AX_W  AR payload
s_r_valid_o/s_r_last_o/s_r_ready_i  out/out/in  NUM_MSTR  R handshake
s_r_pld_o  out  DATA_W+2+ID_W+USER_W  R payload, broadcast
m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  mirror  single-channel  downstream port, same packing
wr_busy_o/rd_busy_o  out  1  path holds a grant
wr_grant_o/rd_grant_o  out  SEL_W  current grant index
wr_len_err_o  out  1  one-cycle pulse on a burst length mismatch

Behaviour:
- Reset: both FSMs go to IDLE; all valid/ready/busy/err outputs are 0; grants are 0; round-robin pointers are NUM_MSTR-1, so master 0 has first priority.
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: if any s_aw_valid_i is set, register the grant and go to W_ADDR. Arbitration latency is 1 cycle; no ready is driven in W_IDLE.
  - Round robin picks the first valid master scanning upward from ptr+1, wrapping at NUM_MSTR-1 to 0.
  - Static mode picks static_sel_i only if that master's valid is set. static_sel_i >= NUM_MSTR gives no grant.
  - W_ADDR: m_aw_valid/payload come from the granted master; s_aw_ready_o[g] = m_aw_ready; others read 0. On the handshake go to W_DATA and latch len; beat count = 0.
  - W_DATA: forward W from the grantee only. On each handshake beat++. On the last=1 handshake go to W_RESP.
  - wr_len_err_o pulses the cycle after a handshake where last=1 and beat != len, or last=0 and beat == len. Beats are still forwarded unchanged; the FSM exits only on last.
  - W_RESP: route m_b_valid to s_b_valid_o[g] and s_b_ready_i[g] to m_b_ready. On the handshake return to W_IDLE and set ptr = g.
- Read FSM states: R_IDLE, R_ADDR, R_DATA. Same arbitration and pointer rules, using its own pointer. R_DATA forwards R to the grantee until rvalid&rready&rlast, then returns to R_IDLE.
- The read and write paths are fully concurrent and may grant the same or different masters.
- Non-granted masters always see ready=0 and valid=0. W offered before AW waits; this is AXI-legal.
- static_en_i and static_sel_i are sampled only in IDLE. Changing them mid-transaction has no effect until the path returns to IDLE.
- busy = state != IDLE. grant holds its value after a transaction until the next grant.
- An asynchronous reset mid-burst aborts immediately with no flush. Upstream and downstream must be reset together.
- Throughput: 1 cycle IDLE bubble per transaction; back-to-back beats within a burst run at full rate.

Test Plan:
- Reset: assert rst_ni=0 mid-W_DATA -> all valid/ready 0 at once, busy=0; after release, master 0 is granted first.
- Fairness: NUM_MSTR=4, all masters hold AW with len=0 continuously -> write grants issue in order 0,1,2,3,0; each gets a B; no starvation across 8 transactions.
- Static mode: static_en_i=1, static_sel_i=2, masters 0 and 2 requesting -> only master 2 is granted. Switching to sel=0 during its W_DATA takes effect only on the next grant.
- Concurrency: master 1 writes len=3 while master 0 reads len=7 -> 4 W beats and 8 R beats reach the correct masters; rd_grant_o=0 and wr_grant_o=1 overlap.
- Length error: AW len=3 with wlast on beat 1 -> wr_len_err_o pulses once, FSM enters W_RESP. Correct len=3 burst -> no pulse.
- Backpressure: m_w_ready toggling 1010 and s_r_ready_i low for 5 cycles -> no beat lost or duplicated; payload compare passes.
